// File: rtl/axis_rdma_segmenter_pkg.sv
// Shared RoCE tx definitions: path-MTU encodings, byte-count helpers and the
// segmenter state encoding.
package axis_rdma_segmenter_pkg;

   localparam logic [2:0] PMTU_256  = 3'd0;
   localparam logic [2:0] PMTU_512  = 3'd1;
   localparam logic [2:0] PMTU_1024 = 3'd2;
   localparam logic [2:0] PMTU_2048 = 3'd3;
   localparam logic [2:0] PMTU_4096 = 3'd4;

   // Widest tkeep supported (DATA_WIDTH = 2048).
   localparam int KEEP_MAX = 256;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEG_HDR  = 2'd1,
      ST_SEG_DATA = 2'd2,
      ST_DRAIN    = 2'd3
   } seg_state_t;

   // Reserved codes 5..7 fall into the default and behave as 4096.
   function automatic logic [12:0] pmtu_bytes(input logic [2:0] code);
      case (code)
         PMTU_256:  return 13'd256;
         PMTU_512:  return 13'd512;
         PMTU_1024: return 13'd1024;
         PMTU_2048: return 13'd2048;
         PMTU_4096: return 13'd4096;
         default:   return 13'd4096;
      endcase
   endfunction

   function automatic logic [8:0] popcount(input logic [KEEP_MAX-1:0] v);
      logic [8:0] n;
      n = 9'd0;
      for (int i = 0; i < KEEP_MAX; i++) begin
         n = n + {8'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/axis_rdma_segmenter_skid_slice.sv
// One-stage AXI-Stream register slice with a skid entry so that the upstream
// ready is a flop output and full throughput is kept under back-pressure.
module axis_skid_slice #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     s_data,
   input  logic [DATA_WIDTH/8-1:0]   s_keep,
   input  logic                      s_last,
   input  logic                      s_user,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic [DATA_WIDTH-1:0]     m_data,
   output logic [DATA_WIDTH/8-1:0]   m_keep,
   output logic                      m_last,
   output logic                      m_user,
   output logic                      m_valid,
   input  logic                      m_ready
);

   localparam int W = DATA_WIDTH + DATA_WIDTH/8 + 2;

   logic [W-1:0] w_in;
   logic [W-1:0] r_out;
   logic [W-1:0] r_skid;
   logic         r_out_valid;
   logic         r_skid_valid;

   assign w_in    = {s_user, s_last, s_keep, s_data};
   assign s_ready = !r_skid_valid;
   assign m_valid = r_out_valid;
   assign {m_user, m_last, m_keep, m_data} = r_out;

   // Output stage refills from the skid entry first so beat order is kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out        <= '0;
         r_skid       <= '0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_out_valid || m_ready) begin
         if (r_skid_valid) begin
            r_out        <= r_skid;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
         end else begin
            r_out_valid <= s_valid;
            if (s_valid) begin
               r_out <= w_in;
            end
         end
      end else if (s_valid && !r_skid_valid) begin
         r_skid       <= w_in;
         r_skid_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/axis_rdma_segmenter.sv
// Splits an RDMA write request plus its AXI-Stream payload into path-MTU sized
// segments: one descriptor per segment and a cut-through payload stream.
module axis_rdma_segmenter
   import axis_rdma_segmenter_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int SEG_IDX_WIDTH = 20
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_wr_req_valid,
   output logic                      s_wr_req_ready,
   input  logic [23:0]               s_wr_req_loc_qp,
   input  logic [31:0]               s_wr_req_dma_length,
   input  logic [63:0]               s_wr_req_addr_offset,
   input  logic                      s_wr_req_is_immediate,
   input  logic [31:0]               s_wr_req_immediate_data,
   input  logic                      s_wr_req_tx_type,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tlast,
   input  logic                      s_axis_tuser,
   output logic                      m_seg_valid,
   input  logic                      m_seg_ready,
   output logic [23:0]               m_seg_loc_qp,
   output logic [63:0]               m_seg_addr_offset,
   output logic [12:0]               m_seg_length,
   output logic                      m_seg_first,
   output logic                      m_seg_last,
   output logic [SEG_IDX_WIDTH-1:0]  m_seg_index,
   output logic                      m_seg_is_immediate,
   output logic [31:0]               m_seg_immediate_data,
   output logic                      m_seg_tx_type,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tuser,
   input  logic [2:0]                pmtu,
   output logic                      status_len_error
);

   seg_state_t               r_state;
   seg_state_t               w_state_nxt;
   logic [23:0]              r_qp;
   logic [31:0]              r_rem;
   logic [12:0]              r_seg_rem;
   logic [63:0]              r_addr;
   logic                     r_is_imm;
   logic [31:0]              r_imm_data;
   logic                     r_tx_type;
   logic [12:0]              r_pmtu;
   logic [SEG_IDX_WIDTH-1:0] r_seg_idx;
   logic                     r_sticky;
   logic                     r_len_err;

   logic                     w_hdr;
   logic                     w_rem_le_pmtu;
   logic [12:0]              w_seg_len;
   logic                     w_req_acc;
   logic                     w_seg_acc;
   logic                     w_slice_valid;
   logic                     w_slice_ready;
   logic                     w_beat;
   logic [KEEP_MAX-1:0]      w_keep_ext;
   logic [12:0]              w_cnt;
   logic                     w_exhaust;
   logic                     w_final_seg;
   logic                     w_err;
   logic                     w_advance;
   logic                     w_out_last;
   logic                     w_out_user;

   assign w_hdr         = (r_state == ST_SEG_HDR);
   assign w_rem_le_pmtu = (r_rem <= {19'd0, r_pmtu});
   assign w_seg_len     = w_rem_le_pmtu ? r_rem[12:0] : r_pmtu;
   assign w_req_acc     = s_wr_req_valid && s_wr_req_ready;
   assign w_seg_acc     = w_hdr && m_seg_ready;
   assign w_slice_valid = (r_state == ST_SEG_DATA) && s_axis_tvalid;
   assign w_beat        = w_slice_valid && w_slice_ready;
   assign w_keep_ext    = KEEP_MAX'(s_axis_tkeep);
   assign w_cnt         = {4'd0, popcount(w_keep_ext)};
   assign w_exhaust     = (w_cnt >= r_seg_rem);
   // r_rem already excludes the current segment, so zero means final segment.
   assign w_final_seg   = (r_rem == 32'd0);

   assign s_wr_req_ready = (r_state == ST_IDLE) && !rst;
   assign s_axis_tready  = !rst && (((r_state == ST_SEG_DATA) && w_slice_ready) ||
                                    (r_state == ST_DRAIN));

   assign m_seg_valid          = w_hdr;
   assign m_seg_loc_qp         = r_qp;
   assign m_seg_addr_offset    = r_addr;
   assign m_seg_length         = w_seg_len;
   assign m_seg_first          = w_hdr && (r_seg_idx == {SEG_IDX_WIDTH{1'b0}});
   assign m_seg_last           = w_hdr && w_rem_le_pmtu;
   assign m_seg_index          = r_seg_idx;
   assign m_seg_is_immediate   = r_is_imm && m_seg_last;
   assign m_seg_immediate_data = r_imm_data;
   assign m_seg_tx_type        = r_tx_type;
   assign status_len_error     = r_len_err;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus the tlast/tuser decoration of the beat being accepted.
   always_comb begin
      w_state_nxt = r_state;
      w_err       = 1'b0;
      w_advance   = 1'b0;
      w_out_last  = 1'b0;
      w_out_user  = s_axis_tuser;
      case (r_state)
         ST_IDLE: begin
            if (w_req_acc) w_state_nxt = ST_SEG_HDR;
            else           w_state_nxt = ST_IDLE;
         end
         ST_SEG_HDR: begin
            if (m_seg_ready) w_state_nxt = (w_seg_len == 13'd0) ? ST_IDLE : ST_SEG_DATA;
            else             w_state_nxt = ST_SEG_HDR;
         end
         ST_SEG_DATA: begin
            if (w_beat && (w_exhaust || s_axis_tlast)) begin
               w_out_last = 1'b1;
               w_out_user = r_sticky | s_axis_tuser;
               if (w_exhaust && s_axis_tlast && w_final_seg) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_exhaust && !s_axis_tlast && !w_final_seg) begin
                  w_advance   = 1'b1;
                  w_state_nxt = ST_SEG_HDR;
               end else if (w_exhaust && !s_axis_tlast) begin
                  w_err       = 1'b1;
                  w_out_user  = 1'b1;
                  w_state_nxt = ST_DRAIN;
               end else begin
                  w_err       = 1'b1;
                  w_out_user  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_state_nxt = ST_SEG_DATA;
            end
         end
         ST_DRAIN: begin
            if (s_axis_tvalid && s_axis_tlast) w_state_nxt = ST_IDLE;
            else                               w_state_nxt = ST_DRAIN;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Request context, byte accounting and the registered length-error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_qp       <= 24'd0;
         r_rem      <= 32'd0;
         r_seg_rem  <= 13'd0;
         r_addr     <= 64'd0;
         r_is_imm   <= 1'b0;
         r_imm_data <= 32'd0;
         r_tx_type  <= 1'b0;
         r_pmtu     <= 13'd0;
         r_seg_idx  <= {SEG_IDX_WIDTH{1'b0}};
         r_sticky   <= 1'b0;
         r_len_err  <= 1'b0;
      end else begin
         r_len_err <= w_err;
         if (w_req_acc) begin
            r_qp       <= s_wr_req_loc_qp;
            r_rem      <= s_wr_req_dma_length;
            r_addr     <= s_wr_req_addr_offset;
            r_is_imm   <= s_wr_req_is_immediate;
            r_imm_data <= s_wr_req_immediate_data;
            r_tx_type  <= s_wr_req_tx_type;
            r_pmtu     <= pmtu_bytes(pmtu);
            r_seg_idx  <= {SEG_IDX_WIDTH{1'b0}};
         end else if (w_seg_acc) begin
            r_seg_rem <= w_seg_len;
            r_rem     <= r_rem - {19'd0, w_seg_len};
            r_sticky  <= 1'b0;
         end else if (w_beat) begin
            r_seg_rem <= w_exhaust ? 13'd0 : (r_seg_rem - w_cnt);
            r_sticky  <= r_sticky | s_axis_tuser;
            if (w_advance) begin
               r_seg_idx <= r_seg_idx + {{(SEG_IDX_WIDTH-1){1'b0}}, 1'b1};
               r_addr    <= r_addr + {51'd0, r_pmtu};
            end
         end
      end
   end

   axis_skid_slice #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .s_data  (s_axis_tdata),
      .s_keep  (s_axis_tkeep),
      .s_last  (w_out_last),
      .s_user  (w_out_user),
      .s_valid (w_slice_valid),
      .s_ready (w_slice_ready),
      .m_data  (m_axis_tdata),
      .m_keep  (m_axis_tkeep),
      .m_last  (m_axis_tlast),
      .m_user  (m_axis_tuser),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready)
   );

endmodule

// File: tb/tb_axis_rdma_segmenter.sv
// Directed bench for axis_rdma_segmenter (DATA_WIDTH=64): segmentation, zero
// length, length errors, back-pressure and reset in mid-segment.
module tb_axis_rdma_segmenter;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_wr_req_valid, s_wr_req_ready;
   logic [23:0] s_wr_req_loc_qp;
   logic [31:0] s_wr_req_dma_length;
   logic [63:0] s_wr_req_addr_offset;
   logic        s_wr_req_is_immediate;
   logic [31:0] s_wr_req_immediate_data;
   logic        s_wr_req_tx_type;
   logic [63:0] s_axis_tdata;
   logic [7:0]  s_axis_tkeep;
   logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
   logic        m_seg_valid, m_seg_ready;
   logic [23:0] m_seg_loc_qp;
   logic [63:0] m_seg_addr_offset;
   logic [12:0] m_seg_length;
   logic        m_seg_first, m_seg_last;
   logic [19:0] m_seg_index;
   logic        m_seg_is_immediate;
   logic [31:0] m_seg_immediate_data;
   logic        m_seg_tx_type;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
   logic [2:0]  pmtu;
   logic        status_len_error;

   int tests = 0;
   int fails = 0;

   logic [63:0] q_data[$];
   logic [7:0]  q_keep[$];
   logic        q_last[$];
   logic        q_user[$];
   logic [12:0] d_len[$];
   logic [63:0] d_off[$];
   logic        d_first[$];
   logic        d_last[$];
   logic        d_imm[$];
   logic [19:0] d_idx[$];
   logic [31:0] d_immd[$];
   int          err_cycles;
   int          err_pulses;
   logic        err_prev;
   logic        rand_out, rand_seg, out_hold;

   always #5 clk = ~clk;

   axis_rdma_segmenter #(.DATA_WIDTH(64), .SEG_IDX_WIDTH(20)) dut (
      .clk(clk), .rst(rst),
      .s_wr_req_valid(s_wr_req_valid), .s_wr_req_ready(s_wr_req_ready),
      .s_wr_req_loc_qp(s_wr_req_loc_qp), .s_wr_req_dma_length(s_wr_req_dma_length),
      .s_wr_req_addr_offset(s_wr_req_addr_offset), .s_wr_req_is_immediate(s_wr_req_is_immediate),
      .s_wr_req_immediate_data(s_wr_req_immediate_data), .s_wr_req_tx_type(s_wr_req_tx_type),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_seg_valid(m_seg_valid), .m_seg_ready(m_seg_ready), .m_seg_loc_qp(m_seg_loc_qp),
      .m_seg_addr_offset(m_seg_addr_offset), .m_seg_length(m_seg_length),
      .m_seg_first(m_seg_first), .m_seg_last(m_seg_last), .m_seg_index(m_seg_index),
      .m_seg_is_immediate(m_seg_is_immediate), .m_seg_immediate_data(m_seg_immediate_data),
      .m_seg_tx_type(m_seg_tx_type),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .pmtu(pmtu), .status_len_error(status_len_error)
   );

   // Payload byte p of a request carries p*7+seed.
   function automatic logic [63:0] beat_data(input int seed, input int b);
      logic [63:0] d;
      for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'((b*8 + i)*7 + seed);
      return d;
   endfunction

   function automatic logic [7:0] beat_keep(input int len, input int b);
      int r;
      r = len - 8*b;
      if (r >= 8 || r <= 0) return 8'hFF;
      return 8'((1 << r) - 1);
   endfunction

   // Monitor: handshakes complete on the next rising edge after this sample.
   initial begin
      forever begin
         @(negedge clk);
         if (m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata); q_keep.push_back(m_axis_tkeep);
            q_last.push_back(m_axis_tlast); q_user.push_back(m_axis_tuser);
         end
         if (m_seg_valid && m_seg_ready) begin
            d_len.push_back(m_seg_length); d_off.push_back(m_seg_addr_offset);
            d_first.push_back(m_seg_first); d_last.push_back(m_seg_last);
            d_imm.push_back(m_seg_is_immediate); d_idx.push_back(m_seg_index);
            d_immd.push_back(m_seg_immediate_data);
         end
         if (status_len_error) err_cycles++;
         if (status_len_error && !err_prev) err_pulses++;
         err_prev = status_len_error;
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         m_axis_tready = rand_out ? ($urandom_range(0, 9) < 3) : out_hold;
         m_seg_ready   = rand_seg ? ($urandom_range(0, 2) == 0) : 1'b1;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
      $fatal(1);
   end

   task automatic clear_caps();
      q_data.delete(); q_keep.delete(); q_last.delete(); q_user.delete();
      d_len.delete(); d_off.delete(); d_first.delete(); d_last.delete();
      d_imm.delete(); d_idx.delete(); d_immd.delete();
      err_cycles = 0; err_pulses = 0;
   endtask

   task automatic send_req(input logic [31:0] len, input logic [63:0] off, input logic imm,
                           input logic [31:0] immd, input logic [2:0] pm);
      int t;
      @(posedge clk); #1;
      s_wr_req_dma_length = len; s_wr_req_addr_offset = off; s_wr_req_is_immediate = imm;
      s_wr_req_immediate_data = immd; s_wr_req_loc_qp = 24'h00ABCD; s_wr_req_tx_type = 1'b1;
      pmtu = pm; s_wr_req_valid = 1'b1; t = 0;
      @(negedge clk);
      while (!s_wr_req_ready && t < 2000) begin @(negedge clk); t++; end
      if (!s_wr_req_ready) begin
         tests++; fails++;
         $display("FAIL req_accept: ready stayed 0 for %0d cycles, required 1", t);
      end
      @(posedge clk); #1;
      s_wr_req_valid = 1'b0;
   endtask

   task automatic drive_payload(input int seed, input int len, input int nbeats, input int last_beat);
      int t;
      for (int b = 0; b < nbeats; b++) begin
         s_axis_tdata = beat_data(seed, b); s_axis_tkeep = beat_keep(len, b);
         s_axis_tlast = (b + 1 == last_beat); s_axis_tuser = 1'b0; s_axis_tvalid = 1'b1; t = 0;
         @(negedge clk);
         while (!s_axis_tready && t < 5000) begin @(negedge clk); t++; end
         if (!s_axis_tready) begin
            tests++; fails++;
            $display("FAIL beat_accept: beat %0d tready=0 after %0d cycles, required 1", b, t);
            break;
         end
         @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int t;
      t = 0;
      while (q_data.size() < n && t < 20000) begin @(negedge clk); t++; end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk); #1;
      tests++;
      if ({s_wr_req_ready, s_axis_tready, m_seg_valid, m_axis_tvalid, status_len_error} !== 5'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b required 00000",
                  {s_wr_req_ready, s_axis_tready, m_seg_valid, m_axis_tvalid, status_len_error});
      end
      tests++;
      if ({m_axis_tdata, m_seg_addr_offset, m_seg_length, m_seg_first, m_seg_last} !== 143'd0) begin
         fails++; $display("FAIL reset_zero: outputs nonzero in reset");
      end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (s_wr_req_ready !== 1'b1) begin
         fails++; $display("FAIL reset_idle: req_ready=%b required 1", s_wr_req_ready);
      end
   endtask

   task automatic test_segment_600();
      logic [12:0] el[3];
      logic [63:0] eo[3];
      logic        eb;
      el = '{13'd256, 13'd256, 13'd88};
      eo = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'h180};
      clear_caps();
      send_req(32'd600, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 32'hCAFE_0001, 3'd0);
      pmtu = 3'd4;
      drive_payload(3, 600, 75, 75);
      wait_out(75);
      tests++;
      if (d_len.size() != 3) begin fails++; $display("FAIL seg600_ndesc: got %0d required 3", d_len.size()); end
      for (int i = 0; i < 3 && i < d_len.size(); i++) begin
         tests++;
         if (d_len[i] !== el[i] || d_off[i] !== eo[i] || d_first[i] !== (i == 0) ||
             d_last[i] !== (i == 2) || d_imm[i] !== (i == 2) || d_idx[i] !== 20'(i)) begin
            fails++;
            $display("FAIL seg600_desc%0d: len %0d off %h f%b l%b imm%b idx%0d, required len %0d off %h f%b l%b imm%b idx%0d",
                     i, d_len[i], d_off[i], d_first[i], d_last[i], d_imm[i], d_idx[i],
                     el[i], eo[i], i == 0, i == 2, i == 2, i);
         end
      end
      tests++;
      if (q_data.size() != 75) begin fails++; $display("FAIL seg600_nbeats: got %0d required 75", q_data.size()); end
      for (int i = 0; i < 75 && i < q_data.size(); i++) begin
         eb = (i == 31 || i == 63 || i == 74);
         tests++;
         if (q_data[i] !== beat_data(3, i) || q_last[i] !== eb || q_user[i] !== 1'b0 || q_keep[i] !== 8'hFF) begin
            fails++;
            $display("FAIL seg600_beat%0d: data %h last %b user %b, required data %h last %b user 0",
                     i, q_data[i], q_last[i], q_user[i], beat_data(3, i), eb);
         end
      end
      tests++;
      if (err_pulses != 0) begin fails++; $display("FAIL seg600_err: got %0d pulses required 0", err_pulses); end
   endtask

   task automatic test_zero_len();
      clear_caps();
      send_req(32'd0, 64'h2000, 1'b1, 32'hDEAD_BEEF, 3'd0);
      repeat (20) @(negedge clk);
      tests++;
      if (d_len.size() != 1) begin
         fails++; $display("FAIL zero_ndesc: got %0d required 1", d_len.size());
      end else if (d_len[0] !== 13'd0 || d_first[0] !== 1'b1 || d_last[0] !== 1'b1 ||
                   d_imm[0] !== 1'b1 || d_immd[0] !== 32'hDEAD_BEEF || d_off[0] !== 64'h2000) begin
         fails++;
         $display("FAIL zero_desc: len %0d f%b l%b imm%b data %h, required 0 1 1 1 deadbeef",
                  d_len[0], d_first[0], d_last[0], d_imm[0], d_immd[0]);
      end
      tests++;
      if (q_data.size() != 0) begin fails++; $display("FAIL zero_beats: got %0d required 0", q_data.size()); end
      tests++;
      if (s_wr_req_ready !== 1'b1 || s_axis_tready !== 1'b0) begin
         fails++; $display("FAIL zero_idle: req_ready %b tready %b required 1 0", s_wr_req_ready, s_axis_tready);
      end
   endtask

   task automatic test_early_tlast();
      clear_caps();
      send_req(32'd256, 64'h0, 1'b0, 32'd0, 3'd0);
      drive_payload(5, 256, 20, 20);
      wait_out(20);
      tests++;
      if (q_data.size() != 20) begin fails++; $display("FAIL early_nbeats: got %0d required 20", q_data.size()); end
      for (int i = 0; i < 20 && i < q_data.size(); i++) begin
         tests++;
         if (q_last[i] !== (i == 19) || q_user[i] !== (i == 19) || q_data[i] !== beat_data(5, i)) begin
            fails++;
            $display("FAIL early_beat%0d: last %b user %b required %b %b", i, q_last[i], q_user[i], i == 19, i == 19);
         end
      end
      tests++;
      if (err_pulses != 1 || err_cycles != 1) begin
         fails++; $display("FAIL early_err: pulses %0d cycles %0d required 1 1", err_pulses, err_cycles);
      end
      tests++;
      if (s_wr_req_ready !== 1'b1) begin fails++; $display("FAIL early_idle: req_ready %b required 1", s_wr_req_ready); end
   endtask

   task automatic test_overrun();
      clear_caps();
      send_req(32'd256, 64'h0, 1'b0, 32'd0, 3'd0);
      drive_payload(9, 256, 40, 40);
      wait_out(32);
      tests++;
      if (q_data.size() != 32) begin fails++; $display("FAIL over_nbeats: got %0d required 32", q_data.size()); end
      for (int i = 0; i < 32 && i < q_data.size(); i++) begin
         tests++;
         if (q_last[i] !== (i == 31) || q_user[i] !== (i == 31) || q_data[i] !== beat_data(9, i)) begin
            fails++;
            $display("FAIL over_beat%0d: last %b user %b required %b %b", i, q_last[i], q_user[i], i == 31, i == 31);
         end
      end
      tests++;
      if (err_pulses != 1 || err_cycles != 1) begin
         fails++; $display("FAIL over_err: pulses %0d cycles %0d required 1 1", err_pulses, err_cycles);
      end
      send_req(32'd16, 64'h40, 1'b0, 32'd0, 3'd0);
      drive_payload(11, 16, 2, 2);
      wait_out(34);
      tests++;
      if (q_data.size() != 34 || d_len.size() != 2) begin
         fails++; $display("FAIL over_next: beats %0d desc %0d required 34 2", q_data.size(), d_len.size());
      end else if (q_data[32] !== beat_data(11, 0) || q_last[33] !== 1'b1 || q_user[33] !== 1'b0 ||
                   d_len[1] !== 13'd16) begin
         fails++; $display("FAIL over_next_data: data %h last %b user %b len %0d", q_data[32], q_last[33], q_user[33], d_len[1]);
      end
   endtask

   task automatic test_backpressure();
      logic [12:0] el[3];
      logic        eb;
      el = '{13'd4096, 13'd4096, 13'd811};
      clear_caps();
      rand_out = 1'b1; rand_seg = 1'b1;
      send_req(32'd9003, 64'h10_0000, 1'b0, 32'd0, 3'd6);
      drive_payload(21, 9003, 1126, 1126);
      wait_out(1126);
      rand_out = 1'b0; rand_seg = 1'b0;
      tests++;
      if (d_len.size() != 3) begin fails++; $display("FAIL bp_ndesc: got %0d required 3", d_len.size()); end
      for (int i = 0; i < 3 && i < d_len.size(); i++) begin
         tests++;
         if (d_len[i] !== el[i] || d_off[i] !== 64'h10_0000 + 64'(i) * 64'h1000) begin
            fails++; $display("FAIL bp_desc%0d: len %0d off %h required %0d", i, d_len[i], d_off[i], el[i]);
         end
      end
      tests++;
      if (q_data.size() != 1126) begin fails++; $display("FAIL bp_nbeats: got %0d required 1126", q_data.size()); end
      for (int i = 0; i < 1126 && i < q_data.size(); i++) begin
         eb = (i == 511 || i == 1023 || i == 1125);
         tests++;
         if (q_data[i] !== beat_data(21, i) || q_keep[i] !== beat_keep(9003, i) || q_last[i] !== eb || q_user[i] !== 1'b0) begin
            fails++;
            $display("FAIL bp_beat%0d: data %h keep %h last %b, required %h %h %b",
                     i, q_data[i], q_keep[i], q_last[i], beat_data(21, i), beat_keep(9003, i), eb);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_caps();
      out_hold = 1'b0;
      send_req(32'd600, 64'h3000, 1'b0, 32'd0, 3'd0);
      drive_payload(4, 600, 2, 0);
      tests++;
      if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL rstmid_inflight: tvalid %b required 1", m_axis_tvalid); end
      rst = 1'b1;
      #1;
      tests++;
      if ({m_axis_tvalid, m_seg_valid, s_axis_tready, s_wr_req_ready, status_len_error, m_axis_tlast} !== 6'b0) begin
         fails++;
         $display("FAIL rstmid_outputs: got %b required 000000",
                  {m_axis_tvalid, m_seg_valid, s_axis_tready, s_wr_req_ready, status_len_error, m_axis_tlast});
      end
      repeat (2) @(posedge clk); #1;
      rst = 1'b0; out_hold = 1'b1;
      clear_caps();
      send_req(32'd600, 64'h3000, 1'b0, 32'd0, 3'd0);
      drive_payload(6, 600, 75, 75);
      wait_out(75);
      tests++;
      if (q_data.size() != 75 || d_len.size() != 3) begin
         fails++; $display("FAIL rstmid_after: beats %0d desc %0d required 75 3", q_data.size(), d_len.size());
      end else if (d_len[2] !== 13'd88 || d_off[1] !== 64'h3100 || d_off[2] !== 64'h3200) begin
         fails++; $display("FAIL rstmid_desc: len2 %0d off1 %h off2 %h required 88 3100 3200", d_len[2], d_off[1], d_off[2]);
      end
      for (int i = 0; i < 75 && i < q_data.size(); i++) begin
         tests++;
         if (q_data[i] !== beat_data(6, i) || q_last[i] !== (i == 31 || i == 63 || i == 74)) begin
            fails++; $display("FAIL rstmid_beat%0d: data %h last %b", i, q_data[i], q_last[i]);
         end
      end
   endtask

   initial begin
      rst = 1'b1; err_prev = 1'b0; err_cycles = 0; err_pulses = 0;
      rand_out = 1'b0; rand_seg = 1'b0; out_hold = 1'b1;
      m_axis_tready = 1'b1; m_seg_ready = 1'b1; pmtu = 3'd0;
      s_wr_req_valid = 1'b0; s_wr_req_loc_qp = 24'd0; s_wr_req_dma_length = 32'd0;
      s_wr_req_addr_offset = 64'd0; s_wr_req_is_immediate = 1'b0;
      s_wr_req_immediate_data = 32'd0; s_wr_req_tx_type = 1'b0;
      s_axis_tdata = 64'd0; s_axis_tkeep = 8'd0; s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
      test_reset();
      test_segment_600();
      test_zero_len();
      test_early_tlast();
      test_overrun();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
